// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link constants and responder state encoding
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_FILL = '1;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE,
    RELOAD
  } spi_state_e;
endpackage

// File: rtl/spi_slave_port_if.sv
// rtl/spi_slave_port_if.sv - local-logic side of the SPI responder (tx holding, rx byte, status pulses)
interface spi_slave_port_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             arrived;
  logic             underrun;
  logic             aborted;
  logic             busy;

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, arrived, underrun, aborted, busy
  );

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, arrived, underrun, aborted, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchronizer with registered rise/fall detect
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - oversampled mode-0 SPI responder with one-deep tx holding register
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL        = {WIDTH{1'b1}}
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic cs_i,
  output logic miso_o,
  spi_slave_port_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sclk_i),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cs_i),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mosi_q <= '0;
    else         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic             hold_full_q, hold_full_d;
  logic             pend_q, pend_d;
  logic             underrun_q, underrun_d, aborted_q, aborted_d;
  logic             load;
  logic [WIDTH-1:0] rx_next;

  assign rx_next = {rx_sr_q[WIDTH-2:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      pend_q      <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      pend_q      <= pend_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    pend_d      = pend_q;
    underrun_d  = 1'b0;
    aborted_d   = 1'b0;
    load        = 1'b0;

    case (state_q)
      // Reset values of the synchronizers look like an idle bus, so demand a real settled idle.
      WAIT_IDLE: begin
        if (cs_s && !sclk_s) begin
          if (cnt_q == CNT_SETTLE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          aborted_d = (cnt_q != '0);
          cnt_d     = '0;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end else if (sclk_rise) begin
          rx_sr_d = rx_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '0 && pend_q) begin
            underrun_d = 1'b1;
            pend_d     = 1'b0;
          end
          if (cnt_q + 1'b1 == CNT_FULL) begin
            rx_data_d = rx_next;
            state_d   = DONE;
          end
        end else if (sclk_fall && cnt_q != '0) begin
          tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = cs_s ? IDLE : RELOAD;
      end
      RELOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = bus.tx_load;
        if (bus.tx_load) hold_d = bus.tx_data;
      end else if (bus.tx_load) begin
        tx_sr_d = bus.tx_data;
      end else begin
        tx_sr_d = FILL;
        // A reload fires on the trailing fall of the previous byte; only flag underrun
        // once the master actually clocks that byte.
        if (state_q == IDLE) underrun_d = 1'b1;
        else                 pend_d     = 1'b1;
      end
    end else if (bus.tx_load && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.arrived  = (state_q == DONE);
  assign bus.underrun = underrun_q;
  assign bus.aborted  = aborted_q;
  assign bus.busy     = ~cs_s;
  assign miso_o       = ~cs_s & tx_sr_q[WIDTH-1];
endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - self-checking bench for spi_slave_port with a queue-based holding model
module tb_spi_slave_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs = 1'b1;
  logic miso;

  spi_slave_port_if bus ();

  spi_slave_port dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sclk_i(sclk),
    .mosi_i(mosi),
    .cs_i  (cs),
    .miso_o(miso),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_arr = 0;
  int n_und = 0;
  int n_abt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.arrived)  n_arr++;
      if (bus.underrun) n_und++;
      if (bus.aborted)  n_abt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic start();
    cs = 1'b0;
    tick(6);
  endtask

  task automatic finish_frame(input int half);
    tick(half);
    cs = 1'b1;
    tick(12);
  endtask

  // Clocks nbits of a mode-0 byte MSB first; optionally loads the holding register during bit 2.
  task automatic xfer_bits(input logic [7:0] tx, input int half, input int nbits,
                           input bit mid, input logic [7:0] mid_val, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(half);
      rx[7-i] = miso;
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      if (mid && i == 2) begin
        check("ready_mid", bus.tx_ready, 1'b1);
        load(mid_val);
      end
    end
  endtask

  logic [7:0] rx, exp, tx, mv;
  logic [7:0] hold_m[$];
  int a0, u0, b0, nb, half, exp_u;
  bit mid;

  initial begin
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    tick(3);
    check("rst_ready", bus.tx_ready, 1'b1);
    check("rst_rx", bus.rx_data, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pulses", {bus.arrived, bus.underrun, bus.aborted}, 3'b000);
    rst_n = 1'b1;
    tick(12);

    // Preloaded single byte
    a0 = n_arr;
    load(8'h2B);
    check("t1_ready_full", bus.tx_ready, 1'b0);
    start();
    check("t1_busy", bus.busy, 1'b1);
    xfer_bits(8'h42, 8, 8, 1'b0, 8'h00, rx);
    check("t1_miso", rx, 8'h2B);
    check("t1_rx", bus.rx_data, 8'h42);
    finish_frame(8);
    check("t1_arrived", n_arr - a0, 1);
    check("t1_ready", bus.tx_ready, 1'b1);

    // Nothing loaded: fill byte and underrun
    u0 = n_und;
    start();
    xfer_bits(8'hAA, 8, 8, 1'b0, 8'h00, rx);
    finish_frame(8);
    check("t2_miso", rx, 8'hFF);
    check("t2_underrun", n_und - u0, 1);
    check("t2_rx", bus.rx_data, 8'hAA);

    // Back-to-back bytes under one CS with a mid-frame load
    a0 = n_arr;
    u0 = n_und;
    load(8'h56);
    start();
    xfer_bits(8'h45, 8, 8, 1'b1, 8'hE3, rx);
    check("t3_miso0", rx, 8'h56);
    check("t3_rx0", bus.rx_data, 8'h45);
    xfer_bits(8'h72, 8, 8, 1'b0, 8'h00, rx);
    check("t3_miso1", rx, 8'hE3);
    finish_frame(8);
    check("t3_rx1", bus.rx_data, 8'h72);
    check("t3_arrived", n_arr - a0, 2);
    check("t3_underrun", n_und - u0, 0);

    // CS released mid-byte
    a0 = n_arr;
    b0 = n_abt;
    start();
    xfer_bits(8'hF3, 8, 5, 1'b0, 8'h00, rx);
    finish_frame(8);
    check("t4_aborted", n_abt - b0, 1);
    check("t4_no_arrived", n_arr - a0, 0);
    check("t4_rx_kept", bus.rx_data, 8'h72);
    start();
    xfer_bits(8'hCD, 6, 8, 1'b0, 8'h00, rx);
    finish_frame(6);
    check("t4_rx_next", bus.rx_data, 8'hCD);
    check("t4_arrived_next", n_arr - a0, 1);

    // Reset mid-frame while CS stays low
    a0 = n_arr;
    start();
    xfer_bits(8'h5A, 8, 3, 1'b0, 8'h00, rx);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("t5_rx_reset", bus.rx_data, 8'h00);
    xfer_bits(8'hA5, 8, 5, 1'b0, 8'h00, rx);
    finish_frame(8);
    check("t5_no_arrived", n_arr - a0, 0);
    start();
    xfer_bits(8'h29, 8, 8, 1'b0, 8'h00, rx);
    finish_frame(8);
    check("t5_rx_new", bus.rx_data, 8'h29);
    check("t5_arrived_new", n_arr - a0, 1);

    // Load strobe in the CS-fall detect cycle, holding empty
    u0 = n_und;
    cs = 1'b0;
    tick(3);
    check("t6_ready_pre", bus.tx_ready, 1'b1);
    bus.tx_data = 8'h8E;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    check("t6_ready_post", bus.tx_ready, 1'b1);
    tick(3);
    xfer_bits(8'h11, 8, 8, 1'b0, 8'h00, rx);
    finish_frame(8);
    check("t6_miso", rx, 8'h8E);
    check("t6_underrun", n_und - u0, 0);

    // Randomized frames against a holding-queue model
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(1, 3);
      half = $urandom_range(5, 10);
      a0 = n_arr;
      u0 = n_und;
      exp_u = 0;
      if ($urandom_range(0, 1) == 1) begin
        mv = 8'($urandom);
        check("r_ready_pre", bus.tx_ready, 1'b1);
        load(mv);
        hold_m.push_back(mv);
      end
      start();
      for (int k = 0; k < nb; k++) begin
        if (hold_m.size() > 0) begin
          exp = hold_m.pop_front();
        end else begin
          exp = 8'hFF;
          exp_u++;
        end
        mid = (k + 1 < nb) && ($urandom_range(0, 1) == 1);
        mv = 8'($urandom);
        tx = 8'($urandom);
        xfer_bits(tx, half, 8, mid, mv, rx);
        if (mid) hold_m.push_back(mv);
        check("r_miso", rx, exp);
        check("r_rx", bus.rx_data, tx);
      end
      finish_frame(half);
      check("r_arrived", n_arr - a0, nb);
      check("r_underrun", n_und - u0, exp_u);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
